// File: rtl/exce_pkg.sv
// Shared exception-capture definitions: fault vector bit map, mcause codes and states.
package exce_pkg;

    localparam int unsigned FLT_W = 9;

    // flt_vec bit indices
    localparam int unsigned FLT_INS_MIS   = 0;
    localparam int unsigned FLT_INS_ACC   = 1;
    localparam int unsigned FLT_LD_MIS    = 2;
    localparam int unsigned FLT_LD_ACC    = 3;
    localparam int unsigned FLT_ST_MIS    = 4;
    localparam int unsigned FLT_ST_ACC    = 5;
    localparam int unsigned FLT_INS_PAGE  = 6;
    localparam int unsigned FLT_LD_PAGE   = 7;
    localparam int unsigned FLT_ST_PAGE   = 8;

    // mcause exception codes
    localparam logic [3:0] CAUSE_INS_MIS  = 4'd0;
    localparam logic [3:0] CAUSE_INS_ACC  = 4'd1;
    localparam logic [3:0] CAUSE_LD_MIS   = 4'd4;
    localparam logic [3:0] CAUSE_LD_ACC   = 4'd5;
    localparam logic [3:0] CAUSE_ST_MIS   = 4'd6;
    localparam logic [3:0] CAUSE_ST_ACC   = 4'd7;
    localparam logic [3:0] CAUSE_INS_PAGE = 4'd12;
    localparam logic [3:0] CAUSE_LD_PAGE  = 4'd13;
    localparam logic [3:0] CAUSE_ST_PAGE  = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } exce_state_e;

endpackage

// File: rtl/exce_prio.sv
// Fixed-priority selection of one fault out of the effective fault vector.
module exce_prio
    import exce_pkg::*;
(
    input  logic [FLT_W-1:0] vec,
    output logic             any,
    output logic [3:0]       code
);

    always_comb begin
        any  = |vec;
        code = 4'd0;
        if (vec[FLT_INS_PAGE])      code = CAUSE_INS_PAGE;
        else if (vec[FLT_INS_ACC])  code = CAUSE_INS_ACC;
        else if (vec[FLT_INS_MIS])  code = CAUSE_INS_MIS;
        else if (vec[FLT_ST_MIS])   code = CAUSE_ST_MIS;
        else if (vec[FLT_LD_MIS])   code = CAUSE_LD_MIS;
        else if (vec[FLT_ST_PAGE])  code = CAUSE_ST_PAGE;
        else if (vec[FLT_LD_PAGE])  code = CAUSE_LD_PAGE;
        else if (vec[FLT_ST_ACC])   code = CAUSE_ST_ACC;
        else if (vec[FLT_LD_ACC])   code = CAUSE_LD_ACC;
    end

endmodule

// File: rtl/exce_capture.sv
// Captures the highest-priority fault into mcause/mtval registers and holds it
// until the trap unit acknowledges; faults arriving while pending are counted.
module exce_capture
    import exce_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned MMU_EN = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FLT_W-1:0] flt_vec,
    input  logic [XLEN-1:0]  flt_addr,
    input  logic             exc_ack,
    input  logic             flush,
    output logic             exc_vld,
    output logic [3:0]       exc_cause,
    output logic [XLEN-1:0]  exc_tval,
    output logic [CNT_W-1:0] drop_cnt
);

    // Page-fault bits are masked off entirely when there is no MMU
    localparam logic [FLT_W-1:0] FLT_MASK = (MMU_EN != 0) ? 9'h1FF : 9'h03F;

    exce_state_e      state;
    logic [FLT_W-1:0] eff_vec;
    logic             flt_any;
    logic [3:0]       flt_code;

    assign eff_vec = flt_vec & FLT_MASK;

    exce_prio u_prio (
        .vec  (eff_vec),
        .any  (flt_any),
        .code (flt_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            exc_vld   <= 1'b0;
            exc_cause <= 4'd0;
            exc_tval  <= '0;
            drop_cnt  <= '0;
        end else if (flush) begin
            state   <= ST_IDLE;
            exc_vld <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flt_any) begin
                        state     <= ST_PEND;
                        exc_vld   <= 1'b1;
                        exc_cause <= flt_code;
                        exc_tval  <= flt_addr;
                    end
                end
                ST_PEND: begin
                    if (exc_ack) begin
                        if (flt_any) begin
                            exc_cause <= flt_code;
                            exc_tval  <= flt_addr;
                        end else begin
                            state   <= ST_IDLE;
                            exc_vld <= 1'b0;
                        end
                    end else if (flt_any && (drop_cnt != {CNT_W{1'b1}})) begin
                        drop_cnt <= drop_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    exc_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/exce_capture.md
EXCE_CAPTURE -- requirements
Module: exce_capture

Interface
REQ-001 SHALL have parameter XLEN, default 32, the width of the fault address and mtval.
REQ-002 SHALL have parameter MMU_EN, default 1; when 0, all page-fault inputs are ignored.
REQ-003 SHALL have parameter CNT_W, default 8, the width of the dropped-fault counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-006 SHALL have port flt_vec, input, 9, fault requests: [0] ins_addr_mis, [1] ins_acc_fault, [2] load_addr_mis, [3] load_acc_fault, [4] st_addr_mis, [5] st_acc_fault, [6] ins_page_fault, [7] ld_page_fault, [8] st_page_fault.
REQ-007 SHALL have port flt_addr, input, XLEN, the faulting virtual address, valid whenever any flt_vec bit is set.
REQ-008 SHALL have port exc_ack, input, 1, the trap unit's acknowledgement that it has consumed the reported exception.
REQ-009 SHALL have port flush, input, 1, which discards any pending exception.
REQ-010 SHALL have port exc_vld, output, 1, asserted when an exception is pending.
REQ-011 SHALL have port exc_cause, output, 4, the mcause exception code.
REQ-012 SHALL have port exc_tval, output, XLEN, the mtval value.
REQ-013 SHALL have port drop_cnt, output, CNT_W, a saturating count of faults lost while pending.

Function
REQ-014 SHALL implement two states: IDLE (exc_vld=0) and PEND (exc_vld=1).
REQ-015 SHALL compute the effective fault vector as flt_vec, with bits [8:6] forced to 0 when MMU_EN=0.
REQ-016 SHALL select one fault by fixed priority, highest first: ins_page(12), ins_acc(1), ins_mis(0), st_mis(6), ld_mis(4), st_page(15), ld_page(13), st_acc(7), ld_acc(5).
REQ-017 SHALL, in IDLE with any effective fault bit set, register the code of the selected fault into exc_cause and flt_addr into exc_tval, and enter PEND; exc_vld rises exactly one cycle after the fault cycle.
REQ-018 SHALL hold exc_cause and exc_tval stable throughout PEND.
REQ-019 SHALL, in PEND with exc_ack=1 and no effective fault, return to IDLE on the next cycle.
REQ-020 SHALL, in PEND with exc_ack=1 and an effective fault in the same cycle, capture the new fault and remain in PEND (back-to-back reporting, no bubble).
REQ-021 SHALL, in PEND with exc_ack=0 and an effective fault, keep the old capture (first fault wins) and increment drop_cnt by 1.
REQ-022 SHALL saturate drop_cnt at 2^CNT_W-1 with no wrap-around; only rst clears it.
REQ-023 SHALL treat exc_ack in IDLE as a no-op.
REQ-024 SHALL give flush priority over everything else: next state IDLE, exc_vld=0, and any fault in the flush cycle is neither captured nor counted.
REQ-025 SHALL keep the output registers (exc_cause, exc_tval) unchanged when returning to IDLE; their values are don't-care while exc_vld=0 but SHALL be deterministic.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set state to IDLE, exc_vld=0, exc_cause=0, exc_tval=0, drop_cnt=0.
REQ-027 SHALL let rst override flush, exc_ack and faults in the same cycle, including when rst is asserted mid-PEND.

Structure
REQ-028 SHALL place the cause-code constants (0,1,4,5,6,7,12,13,15), the flt_vec bit indices and the state encodings in shared package exce_pkg, for reuse by the trap/CSR unit.
REQ-029 SHALL implement the 9-input priority selection as combinational sub-module exce_prio (inputs: effective vector; outputs: any, code[3:0]).
REQ-030 SHALL be implemented in 120-400 lines of RTL.

Verification
REQ-031 SHALL cover: rst; cycle 1 flt_vec=9'h008, flt_addr=32'h8000_0004 -> cycle 2 exc_vld=1, exc_cause=5, exc_tval=32'h8000_0004.
REQ-032 SHALL cover: flt_vec=9'h1FF in IDLE -> exc_cause=12; repeat with MMU_EN=0 and flt_vec=9'h1FF -> exc_cause=1.
REQ-033 SHALL cover: in PEND with exc_ack=0, three cycles of flt_vec=9'h010 -> cause unchanged, drop_cnt=3; with CNT_W=2 and five such cycles -> drop_cnt=3.
REQ-034 SHALL cover: in PEND (cause=5), exc_ack=1 with flt_vec=9'h080, flt_addr=32'h1000 -> next cycle exc_vld=1, exc_cause=13, exc_tval=32'h1000.
REQ-035 SHALL cover: in PEND, flush=1 with exc_ack=1 and flt_vec=9'h002 -> next cycle exc_vld=0, drop_cnt unchanged.
REQ-036 SHALL cover: rst=1 during PEND with flt_vec nonzero -> next cycle all outputs 0.
